ram_lsu_port: RTL and testbench
===============================

// Module: ram_lsu_port
// PURPOSE
//  Initiator side of the byte-lane RAM peripheral: turns one core load/store request into
//  RAM write-strobe/write-data or read-address cycles, then aligns and sign-/zero-extends
//  read data. Sits between the core memory stage and the RAM. One outstanding request;
//  single-pulse response.
// PARAMETERS
//  ADDR_WIDTH      32            core address width
//  DATA_WIDTH      32            data width; 4 byte lanes
//  RAM_ADDR_WIDTH  12            RAM byte-address width (4 KiB)
//  RAM_BASE        32'h1000_0000 RAM base; low RAM_ADDR_WIDTH bits are 0
// PORTS
//  clk            in   1   single clock for all logic
//  rst_n          in   1   asynchronous active-low reset
//  req_i          in   1   request strobe; accepted when req_i & ready_o
//  we_i           in   1   1 = store, 0 = load
//  funct3_i       in   3   000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU: loads only)
//  addr_i         in   32  byte address
//  wdata_i        in   32  store data, right-aligned
//  ready_o        out  1   1 only in IDLE
//  rsp_valid_o    out  1   one-cycle response pulse
//  rsp_err_o      out  1   valid with rsp_valid_o: misaligned, out of range, or bad funct3
//  rdata_o        out  32  load result; held until next response
//  ram_wr_en_o    out  4   byte write strobes, bit n = lane n = bits [8n+7:8n]
//  ram_wr_addr_o  out  32  write address (registered)
//  ram_wr_data_o  out  32  lane-replicated write data
//  ram_rd_addr_o  out  32  read address (registered)
//  ram_rd_data_i  in   32  RAM read data; 1-cycle latency after address is sampled
// BEHAVIOUR
//  Reset: every output 0 except ready_o = 1; state IDLE. Async, so strobes drop at once.
//   A reset mid-operation abandons the request with no response.
//  FSM: IDLE -> ST_RSP | RD_ISSUE | ERR_RSP;  RD_ISSUE -> RD_DATA -> RD_RSP -> IDLE;
//   ST_RSP / ERR_RSP -> IDLE. req_i is ignored outside IDLE.
//  Accept cycle T, in IDLE:
//   - Capture addr, funct3, we and wdata.
//   - Check: range = addr[31:RAM_ADDR_WIDTH] == RAM_BASE[31:RAM_ADDR_WIDTH].
//   - Check: align = H needs addr[0]=0; W needs addr[1:0]=0.
//   - Check: funct3 legal; stores allow only 000/001/010.
//   - Any check fails -> ERR_RSP: no RAM strobes; at T+1 rsp_valid_o=1, rsp_err_o=1.
//     rdata_o is unchanged.
//  Store, T+1 (ST_RSP):
//   - ram_wr_en_o: B = 1<<a[1:0]; H = 4'b0011<<a[1:0]; W = 4'b1111. Asserted exactly
//     one cycle.
//   - ram_wr_data_o: B = {4{wdata[7:0]}}, H = {2{wdata[15:0]}}, W = wdata.
//   - rsp_valid_o=1, err=0. Back in IDLE at T+2.
//  Load:
//   - T+1 RD_ISSUE: ram_rd_addr_o = captured addr; RAM samples it.
//   - T+2 RD_DATA: register ram_rd_data_i.
//   - T+3 RD_RSP: rsp_valid_o=1, err=0. rdata_o = selected lane(s) shifted right by
//     8*a[1:0]. B/H are sign-extended; BU/HU are zero-extended.
//   - Back in IDLE at T+4.
//  ram_wr_en_o is 0 in all states except ST_RSP. Address outputs hold their last value.
//  rsp_valid_o is never high on two consecutive cycles. A request can be accepted on the
//   cycle after a response.
//  Boundaries:
//   - RAM_BASE+0xFFC word is in range.
//   - RAM_BASE+0x1000 -> err.
//   - RAM_BASE-1 -> err; no RAM access.
//   - H at a[1:0]=2'b10 uses lanes 2-3. H at 2'b01/2'b11 -> err.
// TESTING
//  1. Reset asserted -> ready_o=1, ram_wr_en_o=0, rsp_valid_o=0, rdata_o=0.
//  2. SW 0xDEADBEEF @0x1000_0010 -> T+1: wr_en=1111, data=DEADBEEF, rsp_valid=1.
//     LW @0x1000_0010 -> T+3: rdata_o=DEADBEEF.
//  3. SB 0x80 @0x1000_0013 -> wr_en=1000.
//     LB -> 0xFFFF_FF80; LBU -> 0x0000_0080.
//  4. SH 0x8001 @0x1000_0012 -> wr_en=1100.
//     LH -> 0xFFFF_8001; LHU -> 0x0000_8001.
//  5. LW @0x1000_0011; SH @0x1000_0013; SW @0x1000_1000; funct3=011
//     -> T+1: rsp_valid=1, err=1, wr_en=0.
//  6. rst_n low during RD_DATA -> no rsp_valid.
//     Next LW after release completes normally.

Source files
------------

// File: rtl/ram_lsu_port_if.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | ram_lsu_port_if : core load/store request and RAM byte-lane bus bundle    |
// | Revision 1.0                                                              |
// +---------------------------------------------------------------------------+
interface ram_lsu_port_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  req_i;
  logic                  we_i;
  logic [2:0]            funct3_i;
  logic [ADDR_WIDTH-1:0] addr_i;
  logic [DATA_WIDTH-1:0] wdata_i;
  logic                  ready_o;
  logic                  rsp_valid_o;
  logic                  rsp_err_o;
  logic [DATA_WIDTH-1:0] rdata_o;
  logic [3:0]            ram_wr_en_o;
  logic [ADDR_WIDTH-1:0] ram_wr_addr_o;
  logic [DATA_WIDTH-1:0] ram_wr_data_o;
  logic [ADDR_WIDTH-1:0] ram_rd_addr_o;
  logic [DATA_WIDTH-1:0] ram_rd_data_i;

  modport slave (
    input  req_i, we_i, funct3_i, addr_i, wdata_i, ram_rd_data_i,
    output ready_o, rsp_valid_o, rsp_err_o, rdata_o,
           ram_wr_en_o, ram_wr_addr_o, ram_wr_data_o, ram_rd_addr_o
  );

  modport master (
    output req_i, we_i, funct3_i, addr_i, wdata_i, ram_rd_data_i,
    input  ready_o, rsp_valid_o, rsp_err_o, rdata_o,
           ram_wr_en_o, ram_wr_addr_o, ram_wr_data_o, ram_rd_addr_o
  );
endinterface
`default_nettype wire

// File: rtl/ram_lsu_port.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | ram_lsu_port : single-outstanding load/store initiator for byte-lane RAM  |
// | Revision 1.0                                                              |
// +---------------------------------------------------------------------------+
module ram_lsu_port #(
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    RAM_ADDR_WIDTH = 12,
  parameter logic [ADDR_WIDTH-1:0] RAM_BASE       = 32'h1000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  ram_lsu_port_if.slave   bus
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] ST_RSP   = 3'd1;
  localparam logic [2:0] RD_ISSUE = 3'd2;
  localparam logic [2:0] RD_DATA  = 3'd3;
  localparam logic [2:0] RD_RSP   = 3'd4;
  localparam logic [2:0] ERR_RSP  = 3'd5;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  logic [2:0]            state, state_nxt;
  logic                  accept, in_range, aligned, f3_legal, req_ok;
  logic [3:0]            be, be_q, wr_en;
  logic [DATA_WIDTH-1:0] wdata_rep, shifted, load_ext;
  logic [1:0]            off_q;
  logic [2:0]            funct3_q;
  logic [ADDR_WIDTH-1:0] wr_addr, rd_addr;
  logic [DATA_WIDTH-1:0] wr_data, rdata;
  logic                  ready, rsp_valid, rsp_err;

  assign accept = bus.req_i && (state == IDLE);

  // Request qualification and store lane formatting, all from the live request.
  always_comb begin
    in_range = (bus.addr_i[ADDR_WIDTH-1:RAM_ADDR_WIDTH] == RAM_BASE[ADDR_WIDTH-1:RAM_ADDR_WIDTH]);
    aligned  = 1'b1;
    f3_legal = 1'b0;
    be       = 4'b1111;
    wdata_rep = bus.wdata_i;
    case (bus.funct3_i)
      F3_H, F3_HU: aligned = ~bus.addr_i[0];
      F3_W:        aligned = (bus.addr_i[1:0] == 2'b00);
      default:     aligned = 1'b1;
    endcase
    case (bus.funct3_i)
      F3_B, F3_H, F3_W: f3_legal = 1'b1;
      F3_BU, F3_HU:     f3_legal = ~bus.we_i;
      default:          f3_legal = 1'b0;
    endcase
    case (bus.funct3_i)
      F3_B: begin
        be        = 4'b0001 << bus.addr_i[1:0];
        wdata_rep = {4{bus.wdata_i[7:0]}};
      end
      F3_H: begin
        be        = 4'b0011 << bus.addr_i[1:0];
        wdata_rep = {2{bus.wdata_i[15:0]}};
      end
      default: begin
        be        = 4'b1111;
        wdata_rep = bus.wdata_i;
      end
    endcase
    req_ok = in_range && aligned && f3_legal;
  end

  assign shifted = bus.ram_rd_data_i >> {off_q, 3'b000};

  always_comb begin
    case (funct3_q)
      F3_B:    load_ext = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    load_ext = {{16{shifted[15]}}, shifted[15:0]};
      F3_BU:   load_ext = {24'd0, shifted[7:0]};
      F3_HU:   load_ext = {16'd0, shifted[15:0]};
      default: load_ext = shifted;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (!req_ok)        state_nxt = ERR_RSP;
          else if (bus.we_i)  state_nxt = ST_RSP;
          else                state_nxt = RD_ISSUE;
        end
      end
      RD_ISSUE: state_nxt = RD_DATA;
      RD_DATA:  state_nxt = RD_RSP;
      RD_RSP:   state_nxt = IDLE;
      ST_RSP:   state_nxt = IDLE;
      ERR_RSP:  state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ready     = (state == IDLE);
    rsp_valid = (state == ST_RSP) || (state == RD_RSP) || (state == ERR_RSP);
    rsp_err   = (state == ERR_RSP);
    wr_en     = (state == ST_RSP) ? be_q : 4'b0000;
  end

  // Rejected requests touch none of the RAM-facing registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      off_q    <= 2'b00;
      funct3_q <= 3'b000;
      be_q     <= 4'b0000;
      wr_addr  <= '0;
      wr_data  <= '0;
      rd_addr  <= '0;
      rdata    <= '0;
    end else begin
      if (accept && req_ok) begin
        off_q    <= bus.addr_i[1:0];
        funct3_q <= bus.funct3_i;
        if (bus.we_i) begin
          be_q    <= be;
          wr_addr <= bus.addr_i;
          wr_data <= wdata_rep;
        end else begin
          rd_addr <= bus.addr_i;
        end
      end
      if (state == RD_DATA) rdata <= load_ext;
    end
  end

  assign bus.ready_o       = ready;
  assign bus.rsp_valid_o   = rsp_valid;
  assign bus.rsp_err_o     = rsp_err;
  assign bus.rdata_o       = rdata;
  assign bus.ram_wr_en_o   = wr_en;
  assign bus.ram_wr_addr_o = wr_addr;
  assign bus.ram_wr_data_o = wr_data;
  assign bus.ram_rd_addr_o = rd_addr;

endmodule
`default_nettype wire

// File: tb/tb_ram_lsu_port.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_ram_lsu_port : directed bench for ram_lsu_port with a 4 KiB RAM model  |
// | Revision 1.0                                                              |
// +---------------------------------------------------------------------------+
module tb_ram_lsu_port;

  localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  ram_lsu_port_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  ram_lsu_port #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .RAM_ADDR_WIDTH(12), .RAM_BASE(32'h1000_0000)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:1023] = '{default: 32'h0};
  always @(posedge clk) begin
    for (int n = 0; n < 4; n++)
      if (bus.ram_wr_en_o[n]) mem[bus.ram_wr_addr_o[11:2]][8*n +: 8] <= bus.ram_wr_data_o[8*n +: 8];
    bus.ram_rd_data_i <= mem[bus.ram_rd_addr_o[11:2]];
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  // Presents one request once the port is ready; returns 1 ns into the cycle after acceptance.
  task automatic drive(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    int n = 0;
    @(negedge clk);
    while (!bus.ready_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.ready_o) begin
      checks++; errors++;
      $display("FAIL ready_timeout: ready_o=%0b required 1", bus.ready_o);
    end
    bus.req_i = 1'b1; bus.we_i = we; bus.funct3_i = f3; bus.addr_i = a; bus.wdata_i = d;
    @(posedge clk); #1;
    bus.req_i = 1'b0;
  endtask

  task automatic do_load(input logic [2:0] f3, input logic [31:0] a);
    drive(1'b0, f3, a, 32'h0);
    cyc(); cyc();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.req_i = 1'b0; bus.we_i = 1'b0; bus.funct3_i = 3'b0; bus.addr_i = '0; bus.wdata_i = '0;
    #3;
    checks++; if (bus.ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0b required 1", bus.ready_o); end
    checks++; if (bus.ram_wr_en_o !== 4'b0) begin errors++; $display("FAIL reset_wr_en: got %b required 0000", bus.ram_wr_en_o); end
    checks++; if (bus.rsp_valid_o !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %0b required 0", bus.rsp_valid_o); end
    checks++; if (bus.rsp_err_o !== 1'b0) begin errors++; $display("FAIL reset_rsp_err: got %0b required 0", bus.rsp_err_o); end
    checks++; if (bus.rdata_o !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h required 0", bus.rdata_o); end
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_word();
    drive(1'b1, LW, 32'h1000_0010, 32'hDEAD_BEEF);
    checks++; if (bus.ram_wr_en_o !== 4'b1111) begin errors++; $display("FAIL sw_wr_en: got %b required 1111", bus.ram_wr_en_o); end
    checks++; if (bus.ram_wr_data_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL sw_wr_data: got %h required deadbeef", bus.ram_wr_data_o); end
    checks++; if (bus.ram_wr_addr_o !== 32'h1000_0010) begin errors++; $display("FAIL sw_wr_addr: got %h required 10000010", bus.ram_wr_addr_o); end
    checks++; if (bus.rsp_valid_o !== 1'b1 || bus.rsp_err_o !== 1'b0) begin errors++; $display("FAIL sw_rsp: valid=%0b err=%0b required 1/0", bus.rsp_valid_o, bus.rsp_err_o); end
    cyc();
    checks++; if (bus.ram_wr_en_o !== 4'b0) begin errors++; $display("FAIL sw_wr_en_pulse: got %b required 0000", bus.ram_wr_en_o); end
    checks++; if (bus.rsp_valid_o !== 1'b0 || bus.ready_o !== 1'b1) begin errors++; $display("FAIL sw_after: valid=%0b ready=%0b required 0/1", bus.rsp_valid_o, bus.ready_o); end
    drive(1'b0, LW, 32'h1000_0010, 32'h0);
    checks++; if (bus.rsp_valid_o !== 1'b0) begin errors++; $display("FAIL lw_t1_valid: got %0b required 0", bus.rsp_valid_o); end
    checks++; if (bus.ram_rd_addr_o !== 32'h1000_0010) begin errors++; $display("FAIL lw_rd_addr: got %h required 10000010", bus.ram_rd_addr_o); end
    cyc();
    checks++; if (bus.rsp_valid_o !== 1'b0) begin errors++; $display("FAIL lw_t2_valid: got %0b required 0", bus.rsp_valid_o); end
    cyc();
    checks++; if (bus.rsp_valid_o !== 1'b1 || bus.rsp_err_o !== 1'b0) begin errors++; $display("FAIL lw_rsp: valid=%0b err=%0b required 1/0", bus.rsp_valid_o, bus.rsp_err_o); end
    checks++; if (bus.rdata_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lw_rdata: got %h required deadbeef", bus.rdata_o); end
    cyc();
    checks++; if (bus.rsp_valid_o !== 1'b0 || bus.rdata_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lw_hold: valid=%0b rdata=%h required 0/deadbeef", bus.rsp_valid_o, bus.rdata_o); end
  endtask

  task automatic test_byte();
    drive(1'b1, LB, 32'h1000_0013, 32'h0000_0080);
    checks++; if (bus.ram_wr_en_o !== 4'b1000) begin errors++; $display("FAIL sb_wr_en: got %b required 1000", bus.ram_wr_en_o); end
    checks++; if (bus.ram_wr_data_o !== 32'h8080_8080) begin errors++; $display("FAIL sb_wr_data: got %h required 80808080", bus.ram_wr_data_o); end
    do_load(LB, 32'h1000_0013);
    checks++; if (bus.rsp_valid_o !== 1'b1 || bus.rdata_o !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb: valid=%0b rdata=%h required 1/ffffff80", bus.rsp_valid_o, bus.rdata_o); end
    do_load(LBU, 32'h1000_0013);
    checks++; if (bus.rsp_valid_o !== 1'b1 || bus.rdata_o !== 32'h0000_0080) begin errors++; $display("FAIL lbu: valid=%0b rdata=%h required 1/00000080", bus.rsp_valid_o, bus.rdata_o); end
  endtask

  task automatic test_half();
    drive(1'b1, LH, 32'h1000_0012, 32'h0000_8001);
    checks++; if (bus.ram_wr_en_o !== 4'b1100) begin errors++; $display("FAIL sh_wr_en: got %b required 1100", bus.ram_wr_en_o); end
    checks++; if (bus.ram_wr_data_o !== 32'h8001_8001) begin errors++; $display("FAIL sh_wr_data: got %h required 80018001", bus.ram_wr_data_o); end
    do_load(LH, 32'h1000_0012);
    checks++; if (bus.rdata_o !== 32'hFFFF_8001) begin errors++; $display("FAIL lh: got %h required ffff8001", bus.rdata_o); end
    do_load(LHU, 32'h1000_0012);
    checks++; if (bus.rdata_o !== 32'h0000_8001) begin errors++; $display("FAIL lhu: got %h required 00008001", bus.rdata_o); end
    do_load(LH, 32'h1000_0010);
    checks++; if (bus.rdata_o !== 32'hFFFF_BEEF) begin errors++; $display("FAIL lh_low: got %h required ffffbeef", bus.rdata_o); end
    do_load(LB, 32'h1000_0011);
    checks++; if (bus.rdata_o !== 32'hFFFF_FFBE) begin errors++; $display("FAIL lb_lane1: got %h required ffffffbe", bus.rdata_o); end
  endtask

  task automatic test_errors();
    logic        ewe [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [2:0]  ef3 [7] = '{LW, LH, LW, 3'b011, LBU, LW, LH};
    logic [31:0] ead [7] = '{32'h1000_0011, 32'h1000_0013, 32'h1000_1000, 32'h1000_0010,
                             32'h1000_0010, 32'h0FFF_FFFF, 32'h1000_0001};
    for (int i = 0; i < 7; i++) begin
      drive(ewe[i], ef3[i], ead[i], 32'h1234_5678);
      checks++; if (bus.rsp_valid_o !== 1'b1 || bus.rsp_err_o !== 1'b1) begin errors++; $display("FAIL err%0d_rsp: valid=%0b err=%0b required 1/1", i, bus.rsp_valid_o, bus.rsp_err_o); end
      checks++; if (bus.ram_wr_en_o !== 4'b0) begin errors++; $display("FAIL err%0d_wr_en: got %b required 0000", i, bus.ram_wr_en_o); end
      checks++; if (bus.rdata_o !== 32'hFFFF_FFBE) begin errors++; $display("FAIL err%0d_rdata: got %h required ffffffbe", i, bus.rdata_o); end
      checks++; if (bus.ram_rd_addr_o !== 32'h1000_0011 || bus.ram_wr_addr_o !== 32'h1000_0012) begin errors++; $display("FAIL err%0d_addr: rd=%h wr=%h required 10000011/10000012", i, bus.ram_rd_addr_o, bus.ram_wr_addr_o); end
      cyc();
      checks++; if (bus.rsp_valid_o !== 1'b0 || bus.rsp_err_o !== 1'b0) begin errors++; $display("FAIL err%0d_after: valid=%0b err=%0b required 0/0", i, bus.rsp_valid_o, bus.rsp_err_o); end
    end
  endtask

  task automatic test_boundary();
    drive(1'b1, LW, 32'h1000_0FFC, 32'h1122_3344);
    checks++; if (bus.ram_wr_en_o !== 4'b1111 || bus.rsp_err_o !== 1'b0) begin errors++; $display("FAIL top_sw: wr_en=%b err=%0b required 1111/0", bus.ram_wr_en_o, bus.rsp_err_o); end
    do_load(LW, 32'h1000_0FFC);
    checks++; if (bus.rsp_err_o !== 1'b0 || bus.rdata_o !== 32'h1122_3344) begin errors++; $display("FAIL top_lw: err=%0b rdata=%h required 0/11223344", bus.rsp_err_o, bus.rdata_o); end
    do_load(LW, 32'h1000_0000);
    checks++; if (bus.rdata_o !== 32'h0) begin errors++; $display("FAIL base_lw: got %h required 00000000", bus.rdata_o); end
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    drive(1'b0, LW, 32'h1000_0010, 32'h0);
    cyc();
    rst_n = 1'b0;
    #1;
    checks++; if (bus.ready_o !== 1'b1 || bus.rsp_valid_o !== 1'b0) begin errors++; $display("FAIL midrst_async: ready=%0b valid=%0b required 1/0", bus.ready_o, bus.rsp_valid_o); end
    for (int i = 0; i < 3; i++) begin cyc(); if (bus.rsp_valid_o) seen++; end
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin cyc(); if (bus.rsp_valid_o) seen++; end
    checks++; if (seen !== 0) begin errors++; $display("FAIL midrst_no_rsp: pulses=%0d required 0", seen); end
    checks++; if (bus.rdata_o !== 32'h0) begin errors++; $display("FAIL midrst_rdata: got %h required 0", bus.rdata_o); end
    do_load(LW, 32'h1000_0010);
    checks++; if (bus.rsp_valid_o !== 1'b1 || bus.rsp_err_o !== 1'b0 || bus.rdata_o !== 32'h8001_BEEF) begin errors++; $display("FAIL midrst_lw: valid=%0b err=%0b rdata=%h required 1/0/8001beef", bus.rsp_valid_o, bus.rsp_err_o, bus.rdata_o); end
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_errors();
    test_boundary();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
